// File: rtl/zilla_dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter: response states,
// requester IDs, counter widths and the saturating-increment helper.
package zilla_dmem_arbiter_pkg;

`ifdef ZILLA_64_BIT
   localparam int unsigned DMEM_DATA_WIDTH = 64;
`else
   localparam int unsigned DMEM_DATA_WIDTH = 32;
`endif

   localparam int unsigned STARVE_CNT_W = 4;
   localparam int unsigned PERF_CNT_W   = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_CORE = 2'd1,
      RD_DBG  = 2'd2
   } resp_state_e;

   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_CORE = 2'd1,
      REQ_DBG  = 2'd2
   } req_id_e;

   // Counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
      return (&v) ? v : v + PERF_CNT_W'(1);
   endfunction

endpackage

// File: rtl/zilla_dmem_arbiter_if.sv
// Requester/memory bus bundle for the data-memory arbiter.
// Perf counter signals exist only when ZILLA_DMEM_ARB_PERF_EN is defined.
interface zilla_dmem_arbiter_if
   import zilla_dmem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH >> 3
);
   logic                  dbg_mode_i;
   logic                  core_req_i;
   logic                  core_we_i;
   logic [DATA_WIDTH-1:0] core_addr_i;
   logic [DATA_WIDTH-1:0] core_wdata_i;
   logic [STRB_WIDTH-1:0] core_strb_i;
   logic                  core_gnt_o;
   logic                  core_rvalid_o;
   logic                  dbg_req_i;
   logic                  dbg_we_i;
   logic [DATA_WIDTH-1:0] dbg_addr_i;
   logic [DATA_WIDTH-1:0] dbg_wdata_i;
   logic [STRB_WIDTH-1:0] dbg_strb_i;
   logic                  dbg_gnt_o;
   logic                  dbg_rvalid_o;
   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  mem_wr_en_o;
   logic                  mem_rd_en_o;
   logic [DATA_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [STRB_WIDTH-1:0] mem_strb_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;
`ifdef ZILLA_DMEM_ARB_PERF_EN
   logic                  perf_clr_i;
   logic [31:0]           perf_core_gnt_o;
   logic [31:0]           perf_dbg_gnt_o;
   logic [31:0]           perf_conflict_o;
`endif

   modport slave (
      input  dbg_mode_i, core_req_i, core_we_i, core_addr_i, core_wdata_i, core_strb_i,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_strb_i, mem_rdata_i,
      output core_gnt_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o, rdata_o,
      output mem_wr_en_o, mem_rd_en_o, mem_addr_o, mem_wdata_o, mem_strb_o
`ifdef ZILLA_DMEM_ARB_PERF_EN
      , input perf_clr_i
      , output perf_core_gnt_o, perf_dbg_gnt_o, perf_conflict_o
`endif
   );

   modport master (
      output dbg_mode_i, core_req_i, core_we_i, core_addr_i, core_wdata_i, core_strb_i,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_strb_i, mem_rdata_i,
      input  core_gnt_o, core_rvalid_o, dbg_gnt_o, dbg_rvalid_o, rdata_o,
      input  mem_wr_en_o, mem_rd_en_o, mem_addr_o, mem_wdata_o, mem_strb_o
`ifdef ZILLA_DMEM_ARB_PERF_EN
      , output perf_clr_i
      , input perf_core_gnt_o, perf_dbg_gnt_o, perf_conflict_o
`endif
   );
endinterface

// File: rtl/zilla_arb_starve_cnt.sv
// Counts consecutive cycles the core is denied; saturates at MAX_WAIT.
module zilla_arb_starve_cnt
   import zilla_dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic at_max_c
);
   logic [STARVE_CNT_W-1:0] cnt_q;

   assign at_max_c = (cnt_q == STARVE_CNT_W'(MAX_WAIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= STARVE_CNT_W'(0);
      end else if (clr) begin
         cnt_q <= STARVE_CNT_W'(0);
      end else if (inc && !at_max_c) begin
         cnt_q <= cnt_q + STARVE_CNT_W'(1);
      end
   end
endmodule

// File: rtl/zilla_dmem_arbiter.sv
// Core/debug arbiter for the single data-memory port with read-response routing.
// Define ZILLA_DMEM_ARB_PERF_EN to add grant/conflict performance counters.
module zilla_dmem_arbiter
   import zilla_dmem_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH >> 3,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                 mem_clk,
   input  logic                 mem_rst,
   zilla_dmem_arbiter_if.slave  bus
);
   logic        dbg_eff;
   logic        starve_max;
   req_id_e     winner;
   resp_state_e state_q;
   resp_state_e state_d;

   assign dbg_eff = bus.dbg_req_i & bus.dbg_mode_i;

   zilla_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
      .clk      (mem_clk),
      .rst_n    (mem_rst),
      .inc      (bus.core_req_i & ~bus.core_gnt_o),
      .clr      (bus.core_gnt_o | ~bus.core_req_i),
      .at_max_c (starve_max)
   );

   // Debug has priority on conflict unless the core has waited MAX_WAIT cycles.
   always_comb begin
      winner = REQ_NONE;
      if (bus.core_req_i && (!dbg_eff || starve_max)) begin
         winner = REQ_CORE;
      end else if (dbg_eff) begin
         winner = REQ_DBG;
      end
   end

   always_comb begin
      bus.core_gnt_o  = 1'b0;
      bus.dbg_gnt_o   = 1'b0;
      bus.mem_wr_en_o = 1'b0;
      bus.mem_rd_en_o = 1'b0;
      bus.mem_addr_o  = DATA_WIDTH'(0);
      bus.mem_wdata_o = DATA_WIDTH'(0);
      bus.mem_strb_o  = STRB_WIDTH'(0);
      unique case (winner)
         REQ_CORE: begin
            bus.core_gnt_o  = 1'b1;
            bus.mem_wr_en_o = bus.core_we_i;
            bus.mem_rd_en_o = ~bus.core_we_i;
            bus.mem_addr_o  = bus.core_addr_i;
            bus.mem_wdata_o = bus.core_wdata_i;
            bus.mem_strb_o  = bus.core_strb_i;
         end
         REQ_DBG: begin
            bus.dbg_gnt_o   = 1'b1;
            bus.mem_wr_en_o = bus.dbg_we_i;
            bus.mem_rd_en_o = ~bus.dbg_we_i;
            bus.mem_addr_o  = bus.dbg_addr_i;
            bus.mem_wdata_o = bus.dbg_wdata_i;
            bus.mem_strb_o  = bus.dbg_strb_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Response owner is decided purely by who was granted a read last cycle.
   always_comb begin
      state_d           = IDLE;
      bus.core_rvalid_o = 1'b0;
      bus.dbg_rvalid_o  = 1'b0;
      bus.rdata_o       = DATA_WIDTH'(0);
      if (winner == REQ_CORE && !bus.core_we_i) begin
         state_d = RD_CORE;
      end else if (winner == REQ_DBG && !bus.dbg_we_i) begin
         state_d = RD_DBG;
      end
      unique case (state_q)
         RD_CORE: begin
            bus.core_rvalid_o = 1'b1;
            bus.rdata_o       = bus.mem_rdata_i;
         end
         RD_DBG: begin
            bus.dbg_rvalid_o = 1'b1;
            bus.rdata_o      = bus.mem_rdata_i;
         end
         default: ;
      endcase
   end

`ifdef ZILLA_DMEM_ARB_PERF_EN
   logic [PERF_CNT_W-1:0] perf_core_q;
   logic [PERF_CNT_W-1:0] perf_dbg_q;
   logic [PERF_CNT_W-1:0] perf_conf_q;

   always_ff @(posedge mem_clk or negedge mem_rst) begin
      if (!mem_rst) begin
         perf_core_q <= PERF_CNT_W'(0);
         perf_dbg_q  <= PERF_CNT_W'(0);
         perf_conf_q <= PERF_CNT_W'(0);
      end else if (bus.perf_clr_i) begin
         perf_core_q <= PERF_CNT_W'(0);
         perf_dbg_q  <= PERF_CNT_W'(0);
         perf_conf_q <= PERF_CNT_W'(0);
      end else begin
         if (winner == REQ_CORE)          perf_core_q <= sat_inc(perf_core_q);
         if (winner == REQ_DBG)           perf_dbg_q  <= sat_inc(perf_dbg_q);
         if (bus.core_req_i && dbg_eff)   perf_conf_q <= sat_inc(perf_conf_q);
      end
   end

   assign bus.perf_core_gnt_o = perf_core_q;
   assign bus.perf_dbg_gnt_o  = perf_dbg_q;
   assign bus.perf_conflict_o = perf_conf_q;
`else
   // No performance counters in this build.
`endif

endmodule

// File: tb/tb_zilla_dmem_arbiter.sv
// Directed self-checking bench for zilla_dmem_arbiter: vector table plus
// hand-written multi-cycle sequences (starvation, pipelining, reset, mode drop).
module tb_zilla_dmem_arbiter;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   zilla_dmem_arbiter_if #(.DATA_WIDTH(32)) bus ();

   zilla_dmem_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(4)) u_dut (
      .mem_clk (clk),
      .mem_rst (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic        creq;
      logic        cwe;
      logic [31:0] caddr;
      logic [31:0] cwd;
      logic [3:0]  cstrb;
      logic        dreq;
      logic        dwe;
      logic [31:0] daddr;
      logic [31:0] dwd;
      logic [3:0]  dstrb;
      logic        egc;
      logic        egd;
      logic        ewr;
      logic        erd;
      logic [31:0] eaddr;
      logic [31:0] ewd;
      logic [3:0]  estrb;
      logic        ecrv;
      logic        edrv;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_idle(input logic [31:0] rdata);
      bus.core_req_i   = 1'b0;
      bus.core_we_i    = 1'b0;
      bus.core_addr_i  = 32'h0;
      bus.core_wdata_i = 32'h0;
      bus.core_strb_i  = 4'h0;
      bus.dbg_req_i    = 1'b0;
      bus.dbg_we_i     = 1'b0;
      bus.dbg_addr_i   = 32'h0;
      bus.dbg_wdata_i  = 32'h0;
      bus.dbg_strb_i   = 4'h0;
      bus.mem_rdata_i  = rdata;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " core_gnt"},    64'(bus.core_gnt_o),    64'h0);
      chk({tag, " dbg_gnt"},     64'(bus.dbg_gnt_o),     64'h0);
      chk({tag, " core_rvalid"}, 64'(bus.core_rvalid_o), 64'h0);
      chk({tag, " dbg_rvalid"},  64'(bus.dbg_rvalid_o),  64'h0);
      chk({tag, " rdata"},       64'(bus.rdata_o),       64'h0);
      chk({tag, " mem_wr_en"},   64'(bus.mem_wr_en_o),   64'h0);
      chk({tag, " mem_rd_en"},   64'(bus.mem_rd_en_o),   64'h0);
      chk({tag, " mem_addr"},    64'(bus.mem_addr_o),    64'h0);
      chk({tag, " mem_wdata"},   64'(bus.mem_wdata_o),   64'h0);
      chk({tag, " mem_strb"},    64'(bus.mem_strb_o),    64'h0);
`ifdef ZILLA_DMEM_ARB_PERF_EN
      chk({tag, " perf_core"},   64'(bus.perf_core_gnt_o), 64'h0);
      chk({tag, " perf_dbg"},    64'(bus.perf_dbg_gnt_o),  64'h0);
      chk({tag, " perf_conf"},   64'(bus.perf_conflict_o), 64'h0);
`endif
   endtask

   initial begin
      logic [31:0] rd;
      string       t;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      bus.dbg_mode_i = 1'b0;
      drive_idle(32'h0);
`ifdef ZILLA_DMEM_ARB_PERF_EN
      bus.perf_clr_i = 1'b0;
`endif

      // mode, creq, cwe, caddr, cwd, cstrb, dreq, dwe, daddr, dwd, dstrb | gc, gd, wr, rd, addr, wd, strb, crv, drv
      vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'hC0DE, 4'hF, 1'b0, 1'b0, 32'h200, 32'hD0DE, 4'h3,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h100, 32'hC0DE, 4'hF, 1'b0, 1'b0, 32'h200, 32'hD0DE, 4'h3,
                  1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 32'hC0DE, 4'hF, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h11223344, 4'h5, 1'b0, 1'b0, 32'h200, 32'hD0DE, 4'h3,
                  1'b1, 1'b0, 1'b1, 1'b0, 32'h104, 32'h11223344, 4'h5, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'hC0DE, 4'hF, 1'b1, 1'b0, 32'h200, 32'hD0DE, 4'h3,
                  1'b0, 1'b1, 1'b0, 1'b1, 32'h200, 32'hD0DE, 4'h3, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h100, 32'hC0DE, 4'hF, 1'b1, 1'b1, 32'h204, 32'hD0DE, 4'h3,
                  1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h108, 32'hC0DE, 4'hF, 1'b1, 1'b0, 32'h200, 32'hD0DE, 4'h3,
                  1'b1, 1'b0, 1'b0, 1'b1, 32'h108, 32'hC0DE, 4'hF, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h10C, 32'h55, 4'h1, 1'b1, 1'b0, 32'h208, 32'h66, 4'h2,
                  1'b0, 1'b1, 1'b0, 1'b1, 32'h208, 32'h66, 4'h2, 1'b0, 1'b1};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 32'h110, 32'h77, 4'hF, 1'b1, 1'b1, 32'h20C, 32'h88, 4'hC,
                  1'b0, 1'b1, 1'b1, 1'b0, 32'h20C, 32'h88, 4'hC, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'hC0DE, 4'hF, 1'b1, 1'b1, 32'h210, 32'h99, 4'h8,
                  1'b0, 1'b1, 1'b1, 1'b0, 32'h210, 32'h99, 4'h8, 1'b0, 1'b0};

      // Reset state, during and just after release
      repeat (3) @(negedge clk);
      #1 chk_zero("in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_zero("post_reset");

      // Vector table: one request cycle, then an idle cycle for the response
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.dbg_mode_i   = vecs[i].mode;
         bus.core_req_i   = vecs[i].creq;
         bus.core_we_i    = vecs[i].cwe;
         bus.core_addr_i  = vecs[i].caddr;
         bus.core_wdata_i = vecs[i].cwd;
         bus.core_strb_i  = vecs[i].cstrb;
         bus.dbg_req_i    = vecs[i].dreq;
         bus.dbg_we_i     = vecs[i].dwe;
         bus.dbg_addr_i   = vecs[i].daddr;
         bus.dbg_wdata_i  = vecs[i].dwd;
         bus.dbg_strb_i   = vecs[i].dstrb;
         bus.mem_rdata_i  = 32'h0;
         #1;
         t = $sformatf("v%0d", i);
         chk({t, " core_gnt"},  64'(bus.core_gnt_o),  64'(vecs[i].egc));
         chk({t, " dbg_gnt"},   64'(bus.dbg_gnt_o),   64'(vecs[i].egd));
         chk({t, " mem_wr_en"}, 64'(bus.mem_wr_en_o), 64'(vecs[i].ewr));
         chk({t, " mem_rd_en"}, 64'(bus.mem_rd_en_o), 64'(vecs[i].erd));
         chk({t, " mem_addr"},  64'(bus.mem_addr_o),  64'(vecs[i].eaddr));
         chk({t, " mem_wdata"}, 64'(bus.mem_wdata_o), 64'(vecs[i].ewd));
         chk({t, " mem_strb"},  64'(bus.mem_strb_o),  64'(vecs[i].estrb));
         @(negedge clk);
         rd = 32'hA5A5_0000 | 32'(i);
         drive_idle(rd);
         #1;
         chk({t, " core_rvalid"}, 64'(bus.core_rvalid_o), 64'(vecs[i].ecrv));
         chk({t, " dbg_rvalid"},  64'(bus.dbg_rvalid_o),  64'(vecs[i].edrv));
         chk({t, " rdata"}, 64'(bus.rdata_o), (vecs[i].ecrv || vecs[i].edrv) ? 64'(rd) : 64'h0);
      end

      // Sustained conflict: debug wins 4 cycles, core the 5th, counter restarts
      bus.dbg_mode_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.core_req_i = 1'b1; bus.core_we_i = 1'b1; bus.core_addr_i = 32'h300;
         bus.dbg_req_i  = 1'b1; bus.dbg_we_i  = 1'b1; bus.dbg_addr_i  = 32'h400;
         #1;
         t = $sformatf("starve c%0d", i);
         chk({t, " core_gnt"}, 64'(bus.core_gnt_o), (i % 5 == 4) ? 64'h1 : 64'h0);
         chk({t, " dbg_gnt"},  64'(bus.dbg_gnt_o),  (i % 5 == 4) ? 64'h0 : 64'h1);
         chk({t, " mem_addr"}, 64'(bus.mem_addr_o), (i % 5 == 4) ? 64'h300 : 64'h400);
      end
      @(negedge clk);
      drive_idle(32'h0);

      // Back-to-back reads core, dbg, core
      @(negedge clk);
      bus.core_req_i = 1'b1; bus.core_addr_i = 32'h10;
      #1;
      chk("b2b c1 core_gnt", 64'(bus.core_gnt_o), 64'h1);
      chk("b2b c1 mem_addr", 64'(bus.mem_addr_o), 64'h10);
      @(negedge clk);
      drive_idle(32'h1111_0010);
      bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h20;
      #1;
      chk("b2b c2 dbg_gnt",     64'(bus.dbg_gnt_o),     64'h1);
      chk("b2b c2 mem_addr",    64'(bus.mem_addr_o),    64'h20);
      chk("b2b c2 core_rvalid", 64'(bus.core_rvalid_o), 64'h1);
      chk("b2b c2 dbg_rvalid",  64'(bus.dbg_rvalid_o),  64'h0);
      chk("b2b c2 rdata",       64'(bus.rdata_o),       64'h1111_0010);
      @(negedge clk);
      drive_idle(32'h2222_0020);
      bus.core_req_i = 1'b1; bus.core_addr_i = 32'h30;
      #1;
      chk("b2b c3 core_gnt",    64'(bus.core_gnt_o),    64'h1);
      chk("b2b c3 mem_addr",    64'(bus.mem_addr_o),    64'h30);
      chk("b2b c3 dbg_rvalid",  64'(bus.dbg_rvalid_o),  64'h1);
      chk("b2b c3 core_rvalid", 64'(bus.core_rvalid_o), 64'h0);
      chk("b2b c3 rdata",       64'(bus.rdata_o),       64'h2222_0020);
      @(negedge clk);
      drive_idle(32'h3333_0030);
      #1;
      chk("b2b c4 core_rvalid", 64'(bus.core_rvalid_o), 64'h1);
      chk("b2b c4 dbg_rvalid",  64'(bus.dbg_rvalid_o),  64'h0);
      chk("b2b c4 rdata",       64'(bus.rdata_o),       64'h3333_0030);
      @(negedge clk);
      #1;
      chk("b2b c5 core_rvalid", 64'(bus.core_rvalid_o), 64'h0);
      chk("b2b c5 rdata",       64'(bus.rdata_o),       64'h0);

      // Debug mode drops while a debug read is pending: still delivered
      @(negedge clk);
      bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h240;
      #1 chk("mode_fall dbg_gnt", 64'(bus.dbg_gnt_o), 64'h1);
      @(negedge clk);
      drive_idle(32'hBEEF_0240);
      bus.dbg_mode_i = 1'b0;
      #1;
      chk("mode_fall dbg_rvalid",  64'(bus.dbg_rvalid_o),  64'h1);
      chk("mode_fall core_rvalid", 64'(bus.core_rvalid_o), 64'h0);
      chk("mode_fall rdata",       64'(bus.rdata_o),       64'hBEEF_0240);

      // Reset the cycle after a debug read grant drops the response
      @(negedge clk);
      drive_idle(32'h0);
      bus.dbg_mode_i = 1'b1;
      bus.dbg_req_i = 1'b1; bus.dbg_addr_i = 32'h50;
      #1 chk("rst_mid dbg_gnt", 64'(bus.dbg_gnt_o), 64'h1);
      @(negedge clk);
      drive_idle(32'hFFFF_0050);
      rst_n = 1'b0;
      #1 chk_zero("rst_mid assert");
      @(negedge clk);
      #1 chk_zero("rst_mid hold");
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk_zero("rst_mid release");
      @(negedge clk);
      #1 chk_zero("rst_mid after");

`ifdef ZILLA_DMEM_ARB_PERF_EN
      // Three conflict cycles, then clear
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.core_req_i = 1'b1; bus.core_we_i = 1'b1;
         bus.dbg_req_i  = 1'b1; bus.dbg_we_i  = 1'b1;
      end
      @(negedge clk);
      drive_idle(32'h0);
      #1;
      chk("perf conflict", 64'(bus.perf_conflict_o), 64'h3);
      chk("perf dbg_gnt",  64'(bus.perf_dbg_gnt_o),  64'h3);
      chk("perf core_gnt", 64'(bus.perf_core_gnt_o), 64'h0);
      bus.perf_clr_i = 1'b1;
      @(negedge clk);
      bus.perf_clr_i = 1'b0;
      #1 chk_zero("perf cleared");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
